crc24_attach: RTL and testbench

CRC24_ATTACH -- requirements
Module: crc24_attach

---
 rtl/crc_pkg.sv | 37 +++
 rtl/crc24_lfsr.sv | 42 ++++
 rtl/crc24_attach.sv | 142 ++++++++++++++
 tb/tb_crc24_attach.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | crc_pkg : shared constants, FSM encoding and helpers for crc24_attach      |
// | Build option: CRC24_ATTACH_CRC24A_EN selects CRC24A, else CRC24B           |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
package crc_pkg;

  localparam logic [23:0] POLY_CRC24A = 24'h864CFB;
  localparam logic [23:0] POLY_CRC24B = 24'h800063;

`ifdef CRC24_ATTACH_CRC24A_EN
  localparam logic [23:0] POLY = POLY_CRC24A;
`else
  localparam logic [23:0] POLY = POLY_CRC24B;
`endif

  localparam int K_SMALL = 1056;
  localparam int K_LARGE = 6144;
  localparam int CRC_LEN = 24;
  localparam int CNT_W   = 13;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CRC  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Index of the final payload bit for the selected block size.
  function automatic logic [CNT_W-1:0] last_payload_idx(input logic blk);
    return blk ? CNT_W'(K_LARGE - CRC_LEN - 1) : CNT_W'(K_SMALL - CRC_LEN - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc24_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | crc24_lfsr : serial 24-bit CRC register, one message bit per enabled cycle |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module crc24_lfsr
  import crc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic               bit_i,
  output logic [CRC_LEN-1:0] state_o
);

  logic [CRC_LEN-1:0] lfsr_q;
  logic [CRC_LEN-1:0] lfsr_d;
  logic               feedback;

  always_comb begin
    feedback = lfsr_q[CRC_LEN-1] ^ bit_i;
    lfsr_d   = lfsr_q;
    if (clr_i) begin
      lfsr_d = '0;
    end else if (en_i) begin
      lfsr_d = {lfsr_q[CRC_LEN-2:0], 1'b0} ^ (feedback ? POLY : '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/crc24_attach.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | crc24_attach : appends a 24-bit CRC to a serial code-block payload         |
// | Build option: CRC24_ATTACH_CRC24A_EN (CRC24A polynomial, default CRC24B)   |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module crc24_attach
  import crc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic blk_size_in,
  input  logic start_in,
  input  logic in_valid,
  input  logic in_data,
  output logic in_ready,
  output logic crc_start,
  output logic crc_data,
  output logic crc_valid,
  output logic crc_end,
  output logic block_size,
  output logic busy,
  output logic err
);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q;
  logic               crc_start_q;
  logic               crc_data_q;
  logic               crc_valid_q;
  logic               crc_end_q;
  logic               block_size_q;
  logic               busy_q;
  logic               err_q;

  logic [CRC_LEN-1:0] lfsr_state;
  logic               lfsr_clr;
  logic               lfsr_en;

  assign lfsr_clr = (state_q == IDLE) && start_in;
  assign lfsr_en  = (state_q == DATA) && in_valid;

  crc24_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (lfsr_clr),
    .en_i    (lfsr_en),
    .bit_i   (in_data),
    .state_o (lfsr_state)
  );

  // Outputs are registered, so every stream bit appears one cycle after the
  // edge that decided it; the CRC register is frozen once DATA is left.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      in_ready_q   <= 1'b0;
      crc_start_q  <= 1'b0;
      crc_data_q   <= 1'b0;
      crc_valid_q  <= 1'b0;
      crc_end_q    <= 1'b0;
      block_size_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      crc_start_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_in) begin
            block_size_q <= blk_size_in;
            cnt_q        <= '0;
            crc_start_q  <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= HDR;
          end
        end
        HDR: begin
          in_ready_q <= 1'b1;
          state_q    <= DATA;
        end
        DATA: begin
          if (!in_valid) begin
            err_q        <= 1'b1;
            in_ready_q   <= 1'b0;
            crc_valid_q  <= 1'b0;
            crc_data_q   <= 1'b0;
            busy_q       <= 1'b0;
            block_size_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= IDLE;
          end else begin
            crc_data_q  <= in_data;
            crc_valid_q <= 1'b1;
            if (cnt_q == last_payload_idx(block_size_q)) begin
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
              state_q    <= CRC;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        CRC: begin
          crc_data_q  <= lfsr_state[5'(CRC_LEN - 1) - cnt_q[4:0]];
          crc_valid_q <= 1'b1;
          if (cnt_q == CNT_W'(CRC_LEN - 1)) begin
            cnt_q     <= '0;
            crc_end_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          crc_valid_q  <= 1'b0;
          crc_data_q   <= 1'b0;
          crc_end_q    <= 1'b0;
          block_size_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign crc_start  = crc_start_q;
  assign crc_data   = crc_data_q;
  assign crc_valid  = crc_valid_q;
  assign crc_end    = crc_end_q;
  assign block_size = block_size_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_crc24_attach.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_crc24_attach : scoreboard bench for crc24_attach, long-division model   |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_crc24_attach;

`ifdef CRC24_ATTACH_CRC24A_EN
  localparam logic [23:0] C_POLY = 24'h864CFB;
`else
  localparam logic [23:0] C_POLY = 24'h800063;
`endif

  logic clk = 1'b0;
  logic reset;
  logic blk_size_in, start_in, in_valid, in_data;
  logic in_ready, crc_start, crc_data, crc_valid, crc_end, block_size, busy, err;

  crc24_attach dut (
    .clk         (clk),
    .reset       (reset),
    .blk_size_in (blk_size_in),
    .start_in    (start_in),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .crc_start   (crc_start),
    .crc_data    (crc_data),
    .crc_valid   (crc_valid),
    .crc_end     (crc_end),
    .block_size  (block_size),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic d;
    logic e;
  } exp_t;

  exp_t exp_q[$];
  bit   pay [0:6143];
  bit   cap [0:6143];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_start, n_valid, n_end, n_err;
  bit   track_blk = 1'b0;
  logic exp_blk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Remainder of M(x)*x^24 divided by G(x), by schoolbook polynomial division.
  function automatic logic [23:0] div_rem(input int len, input bit from_cap);
    bit          w [0:6167];
    logic [23:0] g;
    logic [23:0] r;
    g = C_POLY;
    for (int i = 0; i < len + 24; i++) begin
      if (i >= len)      w[i] = 1'b0;
      else if (from_cap) w[i] = cap[i];
      else               w[i] = pay[i];
    end
    for (int i = 0; i < len; i++) begin
      if (w[i]) begin
        for (int j = 0; j < 24; j++) w[i + 1 + j] ^= g[23 - j];
      end
    end
    for (int j = 0; j < 24; j++) r[23 - j] = w[len + j];
    return r;
  endfunction

  // Monitor: pops the scoreboard on every valid output bit.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (crc_start) begin
        n_start++;
        chk("hdr_valid_low", 32'(crc_valid), 32'd0);
      end
      if (busy && track_blk) chk("block_size_held", 32'(block_size), 32'(exp_blk));
      if (err) begin
        n_err++;
        chk("err_busy_low", 32'(busy), 32'd0);
        chk("err_valid_low", 32'(crc_valid), 32'd0);
      end
      if (crc_end) n_end++;
      if (crc_valid) begin
        if (n_valid < 6144) cap[n_valid] = crc_data;
        n_valid++;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("stream_data", 32'(crc_data), 32'(e.d));
          chk("stream_end", 32'(crc_end), 32'(e.e));
        end
      end
    end
  end

  // pat: 0 zeros, 1 impulse at bit 0, 2 random. abort_at < 0 means no abort.
  task automatic run_block(input bit blk, input int pat, input int abort_at,
                           input bit ghost, input bit rst_mid);
    int          n;
    int          nexp;
    logic [23:0] crc;
    logic [23:0] got;
    bit          early_drop;
    n = blk ? 6120 : 1032;
    for (int i = 0; i < n; i++) begin
      if (pat == 0)      pay[i] = 1'b0;
      else if (pat == 1) pay[i] = (i == 0);
      else               pay[i] = 1'($urandom_range(0, 1));
    end
    crc  = div_rem(n, 1'b0);
    nexp = (abort_at >= 0) ? abort_at : n;
    for (int i = 0; i < nexp; i++) exp_q.push_back('{d: pay[i], e: 1'b0});
    if (abort_at < 0) begin
      for (int j = 0; j < 24; j++) exp_q.push_back('{d: crc[23 - j], e: (j == 23)});
    end
    n_start = 0; n_valid = 0; n_end = 0; n_err = 0;
    exp_blk = blk; track_blk = 1'b1;

    @(posedge clk); #1;
    start_in = 1'b1; blk_size_in = blk;
    @(posedge clk); #1;
    start_in = 1'b0; in_valid = 1'b1; in_data = pay[0];
    for (int i = 0; i < 8 && !in_ready; i++) begin @(posedge clk); #1; end
    chk("in_ready_rise", 32'(in_ready), 32'd1);
    if (!in_ready) begin
      in_valid = 1'b0; exp_q.delete(); track_blk = 1'b0;
      return;
    end

    early_drop = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_data  = pay[i];
      in_valid = (i != abort_at);
      start_in = ghost && (i == 300);
      @(posedge clk); #1;
      start_in = 1'b0;
      if (i == abort_at) break;
      if (i < n - 1 && !in_ready) early_drop = 1'b1;
      if (i == n - 1) chk("in_ready_fall", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    if (abort_at < 0) chk("in_ready_held", 32'(early_drop), 32'd0);

    if (rst_mid) begin
      for (int i = 0; i < 60 && n_valid < n + 10; i++) begin @(posedge clk); #1; end
      chk("reach_crc_bit10", 32'(n_valid >= n + 10), 32'd1);
      reset = 1'b1;
      #1;
      chk("midreset_outs", 32'({in_ready, crc_start, crc_data, crc_valid,
                               crc_end, block_size, busy, err}), 32'd0);
      exp_q.delete(); track_blk = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midreset_no_end", 32'(n_end), 32'd0);
      chk("midreset_no_err", 32'(n_err), 32'd0);
      return;
    end

    for (int i = 0; i < 80; i++) begin
      if (!busy && exp_q.size() == 0 && (n_end + n_err) > 0) break;
      @(posedge clk); #1;
    end
    chk("block_done", 32'(!busy && exp_q.size() == 0 && (n_end + n_err) > 0), 32'd1);
    chk("start_pulses", 32'(n_start), 32'd1);
    chk("valid_count", 32'(n_valid), 32'(nexp + ((abort_at >= 0) ? 0 : 24)));
    chk("end_pulses", 32'(n_end), (abort_at >= 0) ? 32'd0 : 32'd1);
    chk("err_pulses", 32'(n_err), (abort_at >= 0) ? 32'd1 : 32'd0);
    if (abort_at < 0) begin
      for (int j = 0; j < 24; j++) got[23 - j] = cap[n + j];
      if (pat == 0) chk("zero_crc", 32'(got), 32'd0);
      if (pat == 1) chk("impulse_crc", 32'(got), 32'(crc));
      if (blk && pat == 2) chk("residue", 32'(div_rem(6144, 1'b1)), 32'd0);
    end
    exp_q.delete(); track_blk = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; blk_size_in = 1'b0; start_in = 1'b0; in_valid = 1'b0; in_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'({in_ready, crc_start, crc_data, crc_valid,
                          crc_end, block_size, busy, err}), 32'd0);
    reset = 1'b0;

    run_block(1'b0, 0, -1,  1'b0, 1'b0);  // small, all-zero payload
    run_block(1'b1, 2, -1,  1'b0, 1'b0);  // large, random payload
    run_block(1'b0, 1, -1,  1'b0, 1'b0);  // small, impulse payload
    run_block(1'b0, 2, 500, 1'b0, 1'b0);  // abort at payload bit 500
    run_block(1'b0, 2, -1,  1'b0, 1'b0);  // clean block after abort
    run_block(1'b0, 2, -1,  1'b0, 1'b1);  // reset during CRC bit 10
    run_block(1'b0, 2, -1,  1'b0, 1'b0);  // fresh block after reset
    run_block(1'b0, 2, -1,  1'b1, 1'b0);  // stray start_in during DATA

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
